qsys_event_irq: RTL and testbench
=================================

QSYS_EVENT_IRQ -- requirements
Module: qsys_event_irq

Interface
REQ-001 SHALL have parameter NCH, default 10, number of event channels (1..32); bus bits above NCH-1 read 0 and ignore writes.
REQ-002 SHALL have parameter ID_VALUE, default 32'h51A0_0001, returned by the ID register.
REQ-003 SHALL have ports csi_MCLK_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have ports rsi_MRST_reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports coe_EVT_in  in  NCH  raw fabric event lines.
REQ-006 SHALL have ports avs_S1_address  in  3  word address; avs_S1_read/avs_S1_write  in  1 each  strobes; avs_S1_writedata  in  32; avs_S1_byteenable  in  4.
REQ-007 SHALL have ports avs_S1_readdata  out  32; avs_S1_readdatavalid  out  1; avs_S1_waitrequest  out  1  tied 0.
REQ-008 SHALL have port ins_EVENTS_irq  out  NCH  per-channel interrupt to the SAM9 host bridge EINT lines.

Function
REQ-009 SHALL use this register map: 0 STATUS (RO, conditioned inputs), 1 PENDING (R/W1C), 2 ENABLE (RW), 3 MODE (RW; 0 edge, 1 level), 4 POLARITY (RW; 0 rising/high, 1 falling/low), 5 SET (WO, write-1 sets PENDING; reads 0), 6 ID (RO), 7 reserved (reads 0).
REQ-010 SHALL apply byteenable per byte lane on every writable register; disabled lanes unchanged.
REQ-011 SHALL accept every read in its strobe cycle and assert readdatavalid for exactly one cycle on the next edge with the register value as of the strobe cycle.
REQ-012 SHALL hold readdata at 0 whenever readdatavalid is 0.
REQ-013 SHALL accept back-to-back reads each cycle, one readdatavalid per read, in order.
REQ-014 SHALL ignore a cycle with read and write both asserted except for the write.
REQ-015 SHALL form the conditioned input c = input XOR POLARITY bit, then keep a one-cycle delayed copy d.
REQ-016 SHALL in edge mode set PENDING[i] in the cycle c[i]=1 and d[i]=0.
REQ-017 SHALL in level mode set PENDING[i] every cycle c[i]=1.
REQ-018 SHALL give set (detect or SET write) priority over a same-cycle W1C on the same bit.
REQ-019 SHALL suppress edge detection for one cycle after any write to MODE or POLARITY, so reconfiguration never creates a spurious edge.
REQ-020 SHALL drive ins_EVENTS_irq registered as PENDING AND ENABLE, one edge after PENDING changes.
REQ-021 SHALL let PENDING latch regardless of ENABLE; enabling later raises irq one edge after the ENABLE write.

Reset
REQ-022 SHALL on reset low at a clock edge clear PENDING, ENABLE, MODE, POLARITY, synchronizer and delay registers, readdata, readdatavalid and ins_EVENTS_irq to 0.
REQ-023 SHALL drop an in-flight read when reset occurs (no readdatavalid after reset).
REQ-024 SHALL suppress edge detection in the first cycle after reset release.

Configuration
REQ-025 SHALL honour macro QSYS_EVENT_IRQ_SYNC_EN: when defined, coe_EVT_in passes two flip-flops before the polarity XOR.
REQ-026 SHALL set PENDING 3 edges after an input change with QSYS_EVENT_IRQ_SYNC_EN, and 1 edge without it, where inputs must be csi_MCLK_clk-synchronous.

Verification
REQ-027 SHALL cover: ENABLE=0x001, rising pulse on ch0 -> PENDING=0x001 at edge 3 (sync on); irq[0]=1 at edge 4; W1C 0x001 -> irq[0]=0 one edge later.
REQ-028 SHALL cover: MODE[3]=1, POLARITY[3]=1, ch3 held low, W1C bit3 -> PENDING bit3 still 1; release ch3 high, W1C -> bit3 clears.
REQ-029 SHALL cover: edge detect on ch5 in the same cycle as W1C 0x020 -> PENDING[5] remains 1.
REQ-030 SHALL cover: reads of addr 6 then 0 on consecutive cycles -> readdatavalid two cycles, data ID_VALUE then STATUS, in order.
REQ-031 SHALL cover: write SET with byteenable=0b0010, data 0xFFFF -> only PENDING[9:8] set (NCH=10).
REQ-032 SHALL cover: reset low in the cycle after a read strobe -> no readdatavalid; all registers 0; irq 0.

Source files
------------

// File: rtl/qsys_event_irq.sv
// Event-to-interrupt block: per-channel edge/level capture into PENDING,
// Avalon-MM register file, and registered per-channel interrupt outputs.
//
// Parameters : NCH (event channels, 1..32), ID_VALUE (ID register contents)
// Ports      : csi_MCLK_clk          clock, rising edge
//              rsi_MRST_reset_n      synchronous active-low reset
//              coe_EVT_in            raw event lines [NCH-1:0]
//              avs_S1_*              Avalon-MM slave (address, read, write,
//                                    writedata, byteenable, readdata,
//                                    readdatavalid, waitrequest)
//              ins_EVENTS_irq        per-channel interrupt [NCH-1:0]
// Build macro: QSYS_EVENT_IRQ_SYNC_EN adds a two-flop input synchronizer.
module qsys_event_irq #(
    parameter int          NCH      = 10,
    parameter logic [31:0] ID_VALUE = 32'h51A0_0001
) (
    input  logic           csi_MCLK_clk,
    input  logic           rsi_MRST_reset_n,
    input  logic [NCH-1:0] coe_EVT_in,
    input  logic [2:0]     avs_S1_address,
    input  logic           avs_S1_read,
    input  logic           avs_S1_write,
    input  logic [31:0]    avs_S1_writedata,
    input  logic [3:0]     avs_S1_byteenable,
    output logic [31:0]    avs_S1_readdata,
    output logic           avs_S1_readdatavalid,
    output logic           avs_S1_waitrequest,
    output logic [NCH-1:0] ins_EVENTS_irq
);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] enable;
    logic [NCH-1:0] mode;
    logic [NCH-1:0] polarity;
    logic [NCH-1:0] evt_s;
    logic [NCH-1:0] cond;
    logic [NCH-1:0] cond_d;
    logic [NCH-1:0] detect;
    logic [NCH-1:0] set_vec;
    logic [NCH-1:0] clr_vec;
    logic [NCH-1:0] bmask;
    logic [NCH-1:0] wdata;
    logic [31:0]    lane_mask;
    logic [31:0]    rdata;
    logic [31:0]    rdata_q;
    logic           rvalid_q;
    logic           supp;
    logic           rd_acc;
    logic           wr_pend;
    logic           wr_en;
    logic           wr_mode;
    logic           wr_pol;
    logic           wr_set;
    logic           unused_bits;

`ifdef QSYS_EVENT_IRQ_SYNC_EN
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= coe_EVT_in;
            sync2 <= sync1;
        end
    end

    assign evt_s = sync2;
`else
    assign evt_s = coe_EVT_in;
`endif

    assign lane_mask = {{8{avs_S1_byteenable[3]}}, {8{avs_S1_byteenable[2]}},
                        {8{avs_S1_byteenable[1]}}, {8{avs_S1_byteenable[0]}}};
    assign bmask     = lane_mask[NCH-1:0];
    assign wdata     = avs_S1_writedata[NCH-1:0] & bmask;

    assign unused_bits = ^{avs_S1_writedata, lane_mask};

    // A read strobe that coincides with a write is discarded.
    assign rd_acc  = avs_S1_read && !avs_S1_write;
    assign wr_pend = avs_S1_write && (avs_S1_address == 3'd1);
    assign wr_en   = avs_S1_write && (avs_S1_address == 3'd2);
    assign wr_mode = avs_S1_write && (avs_S1_address == 3'd3);
    assign wr_pol  = avs_S1_write && (avs_S1_address == 3'd4);
    assign wr_set  = avs_S1_write && (avs_S1_address == 3'd5);

    assign cond = evt_s ^ polarity;

    // Edge detection is blanked for one cycle after reset release and after
    // any MODE/POLARITY write, so the delayed copy catches up first.
    assign detect  = (mode & cond) | (~mode & cond & ~cond_d & {NCH{~supp}});
    assign set_vec = detect | (wr_set ? wdata : '0);
    assign clr_vec = wr_pend ? wdata : '0;

    always_comb begin
        rdata = '0;
        unique case (avs_S1_address)
            3'd0:    rdata = 32'(cond);
            3'd1:    rdata = 32'(pending);
            3'd2:    rdata = 32'(enable);
            3'd3:    rdata = 32'(mode);
            3'd4:    rdata = 32'(polarity);
            3'd6:    rdata = ID_VALUE;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            pending        <= '0;
            enable         <= '0;
            mode           <= '0;
            polarity       <= '0;
            cond_d         <= '0;
            supp           <= 1'b1;
            rdata_q        <= '0;
            rvalid_q       <= 1'b0;
            ins_EVENTS_irq <= '0;
        end else begin
            // Set wins over a same-cycle write-1-to-clear.
            pending  <= (pending & ~clr_vec) | set_vec;
            if (wr_en)
                enable <= (enable & ~bmask) | wdata;
            if (wr_mode)
                mode <= (mode & ~bmask) | wdata;
            if (wr_pol)
                polarity <= (polarity & ~bmask) | wdata;
            cond_d         <= cond;
            supp           <= wr_mode || wr_pol;
            rdata_q        <= rd_acc ? rdata : '0;
            rvalid_q       <= rd_acc;
            ins_EVENTS_irq <= pending & enable;
        end
    end

    // Gating with reset drops a response whose strobe preceded reset.
    assign avs_S1_readdatavalid = rvalid_q && rsi_MRST_reset_n;
    assign avs_S1_readdata      = rsi_MRST_reset_n ? rdata_q : '0;
    assign avs_S1_waitrequest   = 1'b0;

endmodule

// File: tb/tb_qsys_event_irq.sv
// Scoreboard bench for qsys_event_irq: reads push expected data into a
// queue, a negedge monitor pops on readdatavalid; irq checked directly.
module tb_qsys_event_irq;

    localparam int NCH = 10;
    localparam logic [31:0] ID = 32'h51A0_0001;
`ifdef QSYS_EVENT_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] evt;
    logic [2:0]     addr;
    logic           rd;
    logic           wr;
    logic [31:0]    wdata;
    logic [3:0]     be;
    logic [31:0]    rdata;
    logic           rvalid;
    logic           wait_r;
    logic [NCH-1:0] irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    int          addr_q[$];

    qsys_event_irq #(.NCH(NCH), .ID_VALUE(ID)) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset_n     (rst_n),
        .coe_EVT_in           (evt),
        .avs_S1_address       (addr),
        .avs_S1_read          (rd),
        .avs_S1_write         (wr),
        .avs_S1_writedata     (wdata),
        .avs_S1_byteenable    (be),
        .avs_S1_readdata      (rdata),
        .avs_S1_readdatavalid (rvalid),
        .avs_S1_waitrequest   (wait_r),
        .ins_EVENTS_irq       (irq)
    );

    always #5 clk = ~clk;

    // Monitor: compare every read response with the scoreboard head.
    always @(negedge clk) begin
        if (rvalid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rvalid data=%h", rdata);
            end else begin
                logic [31:0] e;
                int          a;
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                if (rdata !== e) begin
                    bad++;
                    $display("FAIL read_addr%0d got=%h exp=%h", a, rdata, e);
                end
            end
        end else if (rdata !== 32'h0) begin
            total++;
            bad++;
            $display("FAIL rdata_idle got=%h exp=0", rdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input int a, input logic [31:0] exp);
        rd   = 1'b1;
        addr = 3'(a);
        exp_q.push_back(exp);
        addr_q.push_back(a);
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic wr_reg(input int a, input logic [31:0] d, input logic [3:0] b);
        wr    = 1'b1;
        addr  = 3'(a);
        wdata = d;
        be    = b;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic chk_irq(input string name, input logic [NCH-1:0] exp);
        @(negedge clk);
        chk(name, 32'(irq), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        evt   = '0;
        addr  = '0;
        rd    = 1'b0;
        wr    = 1'b0;
        wdata = '0;
        be    = '0;
        idle(3);
        chk_irq("reset_irq", '0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("waitrequest", 32'(wait_r), 32'h0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++)
            rd_reg(i, (i == 6) ? ID : 32'h0);

        // Edge on ch0 with ENABLE[0]; irq follows pending; W1C drops it.
        wr_reg(2, 32'h001, 4'hF);
        evt[0] = 1'b1;
        idle(1);
        evt[0] = 1'b0;
        idle(LAT - 1);
        chk_irq("irq0_pre", '0);
        idle(1);
        chk_irq("irq0_set", 10'h001);
        rd_reg(1, 32'h001);
        wr_reg(1, 32'h001, 4'hF);
        chk_irq("irq0_hold", 10'h001);
        idle(1);
        chk_irq("irq0_clr", '0);
        rd_reg(1, 32'h0);

        // Level, active-low ch3: W1C cannot clear while asserted.
        wr_reg(3, 32'h008, 4'hF);
        wr_reg(4, 32'h008, 4'hF);
        idle(2);
        rd_reg(0, 32'h008);
        wr_reg(1, 32'h008, 4'hF);
        rd_reg(1, 32'h008);
        evt[3] = 1'b1;
        idle(LAT + 1);
        wr_reg(1, 32'h008, 4'hF);
        rd_reg(1, 32'h0);
        // Back to edge/high with ch3 high: no spurious edge.
        wr_reg(3, 32'h0, 4'hF);
        wr_reg(4, 32'h0, 4'hF);
        idle(LAT + 1);
        rd_reg(1, 32'h0);
        evt[3] = 1'b0;
        idle(LAT + 1);

        // Edge on ch5 in the same cycle as W1C of bit 5.
        evt[5] = 1'b1;
        idle(LAT - 1);
        wr_reg(1, 32'h020, 4'hF);
        rd_reg(1, 32'h020);
        wr_reg(1, 32'h020, 4'hF);
        rd_reg(1, 32'h0);

        // Back-to-back reads, in order.
        rd_reg(6, ID);
        rd_reg(0, 32'h020);

        // SET through lane 1 only.
        wr_reg(5, 32'h0000_FFFF, 4'b0010);
        rd_reg(1, 32'h300);
        rd_reg(5, 32'h0);
        chk_irq("irq_en0", '0);
        wr_reg(2, 32'hFFFF_FFFF, 4'hF);
        rd_reg(2, 32'h3FF);
        wr_reg(2, 32'h0, 4'hF);
        wr_reg(2, 32'h300, 4'b0001);
        rd_reg(2, 32'h0);
        wr_reg(2, 32'h300, 4'b0010);
        chk_irq("irq_late_pre", '0);
        idle(1);
        chk_irq("irq_late", 10'h300);

        // Read and write together: only the write happens.
        rd    = 1'b1;
        wr    = 1'b1;
        addr  = 3'd2;
        wdata = 32'h001;
        be    = 4'hF;
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        rd_reg(2, 32'h001);
        wr_reg(2, 32'h300, 4'hF);
        idle(1);
        chk_irq("irq_pre_rst", 10'h300);

        // Reset right after a read strobe drops the response.
        evt[5] = 1'b0;
        idle(LAT + 1);
        rd   = 1'b1;
        addr = 3'd6;
        @(posedge clk);
        #1;
        rd    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        idle(2);
        chk_irq("rst_irq", '0);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++)
            rd_reg(i, (i == 6) ? ID : 32'h0);

        idle(4);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
